cacheline_adaptor: RTL

Sits between the processor's memory-side port and the physical memory model in the test harness. Upstream side: one 256-bit cacheline request (read or write) from the cache arbiter. Downstream side: the same transfer as a 4-beat, 64-bit burst on the pmem interface. Holds all burst sequencing, beat counting and line assembly/disassembly so the caches see a single line-granular handshake.

---
 rtl/cacheline_adaptor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Cacheline <-> 4-beat pmem burst adaptor: one 256-bit line handshake upstream, 64-bit beats downstream.
// Optional stall watchdog with sticky err_o: define CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor #(
    parameter int BEAT_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINE_WIDTH-1:0] line_i,
    output logic [LINE_WIDTH-1:0] line_o,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    output logic                  resp_o,
    input  logic [BEAT_WIDTH-1:0] burst_i,
    output logic [BEAT_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic                  resp_i
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    ,
    output logic                  err_o
`endif
);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0]     buf_q, buf_d;
    logic [ADDR_WIDTH-1:OFF]   addr_q, addr_d;
    logic [BEAT_WIDTH-1:0]     burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]     addr_o_q, addr_o_d;
    logic                      read_q, read_d, write_q, write_d, resp_q, resp_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    logic [15:0]               idle_q, idle_d;
    logic                      err_q, err_d;
`endif

    // Byte-offset bits are dropped: bursts always start on a line boundary.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[OFF-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        burst_d  = '0;
        addr_o_d = '0;
        read_d   = 1'b0;
        write_d  = 1'b0;
        resp_d   = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        idle_d   = '0;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (read_i) begin
                    addr_d   = address_i[ADDR_WIDTH-1:OFF];
                    addr_o_d = {address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    read_d   = 1'b1;
                    state_d  = READ;
                end else if (write_i) begin
                    addr_d   = address_i[ADDR_WIDTH-1:OFF];
                    addr_o_d = {address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    buf_d    = line_i;
                    burst_d  = line_i[BEAT_WIDTH-1:0];
                    write_d  = 1'b1;
                    state_d  = WRITE;
                end
            end
            READ, WRITE: begin
                addr_o_d = {addr_q, {OFF{1'b0}}};
                read_d   = (state_q == READ);
                write_d  = (state_q == WRITE);
                if (resp_i) begin
                    if (state_q == READ) buf_d[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] = burst_i;
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        addr_o_d = '0;
                        read_d   = 1'b0;
                        write_d  = 1'b0;
                        resp_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
                else if (idle_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    cnt_d    = '0;
                    addr_o_d = '0;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    resp_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
`endif
                if (state_d == WRITE) burst_d = buf_q[BEAT_WIDTH*cnt_d +: BEAT_WIDTH];
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            buf_q    <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            addr_o_q <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            resp_q   <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            idle_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            addr_o_q <= addr_o_d;
            read_q   <= read_d;
            write_q  <= write_d;
            resp_q   <= resp_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
            idle_q   <= idle_d;
            err_q    <= err_d;
`endif
        end
    end

    assign line_o    = buf_q;
    assign burst_o   = burst_q;
    assign address_o = addr_o_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    assign err_o     = err_q;
`endif
endmodule
